// File: rtl/matmul_pkg.sv
// Shared types and widths for the sequential matrix-multiply engine.
package matmul_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int ADDR_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MAC  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } mm_state_t;

  // Row-major element address: base + row*n + col, wrapping at 8 bits.
  function automatic logic [ADDR_W-1:0] mat_addr(
    input logic [ADDR_W-1:0] base,
    input logic [IDX_W-1:0]  row,
    input logic [IDX_W-1:0]  col,
    input logic [ADDR_W-1:0] n
  );
    logic [ADDR_W-1:0] row_w;
    logic [ADDR_W-1:0] col_w;
    row_w = {5'd0, row};
    col_w = {5'd0, col};
    return base + (row_w * n) + col_w;
  endfunction

endpackage

// File: rtl/matmul_seq_mac16.sv
// 8x8 unsigned multiplier feeding a 16-bit wrapping accumulator.
module mac16
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] prod_s;

  assign prod_s = {8'd0, a} * {8'd0, b};

  // Accumulator: clear has priority, otherwise add the product modulo 2^16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 16'd0;
    end else if (clr) begin
      acc <= 16'd0;
    end else if (en) begin
      acc <= acc + prod_s;
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential C = A*B engine: one multiply-accumulate per three-cycle step,
// operands read from and results written to an adjacent data memory.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int A_BASE = 0,
  parameter int B_BASE = 4,
  parameter int C_BASE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ACC_W-1:0]  w_data
);

  localparam logic [ADDR_W-1:0] N_W      = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] A_BASE_W = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] B_BASE_W = ADDR_W'(B_BASE);
  localparam logic [ADDR_W-1:0] C_BASE_W = ADDR_W'(C_BASE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

  mm_state_t          state_r;
  mm_state_t          state_s;
  logic [IDX_W-1:0]   i_r;
  logic [IDX_W-1:0]   j_r;
  logic [IDX_W-1:0]   k_r;
  logic [DATA_W-1:0]  a_reg_r;
  logic [ADDR_W-1:0]  r_addr_hold_r;
  logic [ACC_W-1:0]   acc_s;
  logic               mac_clr_s;
  logic               mac_en_s;

  mac16 u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr_s),
    .en  (mac_en_s),
    .a   (a_reg_r),
    .b   (r_data),
    .acc (acc_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RD_A;
        else       state_s = IDLE;
      end
      RD_A: state_s = RD_B;
      RD_B: state_s = MAC;
      MAC: begin
        if (k_r == LAST_IDX) state_s = WR;
        else                 state_s = RD_A;
      end
      WR: begin
        if ((i_r == LAST_IDX) && (j_r == LAST_IDX)) state_s = DONE;
        else                                         state_s = RD_A;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Outputs decoded from registered state and registered datapath values only.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    we        = 1'b0;
    w_addr    = 8'd0;
    w_data    = 16'd0;
    r_addr    = r_addr_hold_r;
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    case (state_r)
      IDLE: mac_clr_s = 1'b1;
      RD_A: begin
        busy   = 1'b1;
        r_addr = mat_addr(A_BASE_W, i_r, k_r, N_W);
      end
      RD_B: begin
        busy   = 1'b1;
        r_addr = mat_addr(B_BASE_W, k_r, j_r, N_W);
      end
      MAC: begin
        busy     = 1'b1;
        mac_en_s = 1'b1;
      end
      WR: begin
        busy      = 1'b1;
        we        = 1'b1;
        w_addr    = mat_addr(C_BASE_W, i_r, j_r, N_W);
        w_data    = acc_s;
        mac_clr_s = 1'b1;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Read address holds its last presented value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hold_r <= 8'd0;
    end else begin
      r_addr_hold_r <= r_addr;
    end
  end

  // Index counters and A-operand latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_r     <= 3'd0;
      j_r     <= 3'd0;
      k_r     <= 3'd0;
      a_reg_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          i_r <= 3'd0;
          j_r <= 3'd0;
          k_r <= 3'd0;
        end
        RD_B: a_reg_r <= r_data;
        MAC: begin
          if (k_r != LAST_IDX) k_r <= k_r + 3'd1;
          else                 k_r <= k_r;
        end
        WR: begin
          k_r <= 3'd0;
          if (j_r == LAST_IDX) begin
            j_r <= 3'd0;
            if (i_r == LAST_IDX) i_r <= 3'd0;
            else                 i_r <= i_r + 3'd1;
          end else begin
            j_r <= j_r + 3'd1;
          end
        end
        default: begin
          i_r <= i_r;
          j_r <= j_r;
          k_r <= k_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench: two engines (N=2 and N=8) beside behavioural memories,
// results compared against a plain-arithmetic matrix product.
module tb_matmul_seq;

  logic        clk = 1'b0;
  logic        rst2, rst8;
  logic        start2, start8;
  logic        busy2, busy8, done2, done8, we2, we8;
  logic [7:0]  r_addr2, r_addr8, w_addr2, w_addr8;
  logic [7:0]  rd2, rd8;
  logic [15:0] w_data2, w_data8;

  logic        ld_we2, ld_we8;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  logic [15:0] mem2 [256];
  logic [15:0] mem8 [256];
  logic [7:0]  wlog2 [256];
  logic [7:0]  wlog8 [256];
  int          wr_cnt2 = 0;
  int          wr_cnt8 = 0;

  int          a_m [64];
  int          b_m [64];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  matmul_seq u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
    .r_addr(r_addr2), .r_data(rd2), .we(we2), .w_addr(w_addr2), .w_data(w_data2)
  );

  matmul_seq #(.N(8), .A_BASE(0), .B_BASE(64), .C_BASE(128)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .busy(busy8), .done(done8),
    .r_addr(r_addr8), .r_data(rd8), .we(we8), .w_addr(w_addr8), .w_data(w_data8)
  );

  // Behavioural memories: 1-cycle read of the low byte, 16-bit writes, bench load port.
  always @(posedge clk) begin
    if (we2) begin
      mem2[w_addr2] <= w_data2;
      wlog2[wr_cnt2 % 256] <= w_addr2;
      wr_cnt2 <= wr_cnt2 + 1;
    end else if (ld_we2) begin
      mem2[ld_addr] <= ld_data;
    end
    rd2 <= mem2[r_addr2][7:0];
    if (we8) begin
      mem8[w_addr8] <= w_data8;
      wlog8[wr_cnt8 % 256] <= w_addr8;
      wr_cnt8 <= wr_cnt8 + 1;
    end else if (ld_we8) begin
      mem8[ld_addr] <= ld_data;
    end
    rd8 <= mem8[r_addr8][7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_c(input int n, input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < n; k++) s += a_m[i*n+k] * b_m[k*n+j];
    return s % 65536;
  endfunction

  function automatic int b_base(input int n);
    return (n == 2) ? 4 : 64;
  endfunction

  function automatic int c_base(input int n);
    return (n == 2) ? 8 : 128;
  endfunction

  task automatic poke(input int n, input int addr, input int data);
    @(negedge clk);
    ld_we2  = (n == 2);
    ld_we8  = (n == 8);
    ld_addr = 8'(addr);
    ld_data = 16'(data);
  endtask

  // Load A, B and a sentinel over the C region.
  task automatic load(input int n);
    for (int e = 0; e < n*n; e++) begin
      poke(n, e, a_m[e]);
      poke(n, b_base(n) + e, b_m[e]);
      poke(n, c_base(n) + e, 16'hBEEF);
    end
    @(negedge clk);
    ld_we2 = 1'b0;
    ld_we8 = 1'b0;
  endtask

  task automatic run_mm(input int n, input bit extra);
    int cyc, base, exp_cyc;
    bit found;
    logic [15:0] got;
    exp_cyc = n*n*(3*n+1) + 1;
    base = (n == 2) ? wr_cnt2 : wr_cnt8;
    @(negedge clk);
    if (n == 2) start2 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    cyc = 1;
    found = 1'b0;
    while (cyc <= 3000) begin
      if (n == 2) start2 = extra && (cyc == 5 || cyc == 20);
      else        start8 = 1'b0;
      if (cyc == 1) check("busy_cyc1", 32'((n == 2) ? busy2 : busy8), 32'd1);
      if ((n == 2) ? done2 : done8) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start2 = 1'b0;
    start8 = 1'b0;
    check("done_seen", 32'(found), 32'd1);
    check("done_cycle", 32'(cyc), 32'(exp_cyc));
    check("busy_at_done", 32'((n == 2) ? busy2 : busy8), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'((n == 2) ? done2 : done8), 32'd0);
    check("write_count", 32'(((n == 2) ? wr_cnt2 : wr_cnt8) - base), 32'(n*n));
    for (int e = 0; e < n*n; e++) begin
      check("write_order", 32'((n == 2) ? wlog2[(base+e)%256] : wlog8[(base+e)%256]),
            32'(c_base(n) + e));
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        got = (n == 2) ? mem2[c_base(n)+i*n+j] : mem8[c_base(n)+i*n+j];
        check("c_value", 32'(got), 32'(model_c(n, i, j)));
      end
    end
  endtask

  task automatic set_n2(input int a0, a1, a2, a3, b0, b1, b2, b3);
    a_m[0] = a0; a_m[1] = a1; a_m[2] = a2; a_m[3] = a3;
    b_m[0] = b0; b_m[1] = b1; b_m[2] = b2; b_m[3] = b3;
  endtask

  initial begin
    int base, wait_cyc;
    rst2 = 1'b1; rst8 = 1'b1;
    start2 = 1'b0; start8 = 1'b0;
    ld_we2 = 1'b0; ld_we8 = 1'b0; ld_addr = 8'd0; ld_data = 16'd0;
    #1;
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_done", 32'(done2), 32'd0);
    check("rst_we", 32'(we2), 32'd0);
    check("rst_r_addr", 32'(r_addr2), 32'd0);
    check("rst_w_addr", 32'(w_addr2), 32'd0);
    check("rst_w_data", 32'(w_data2), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    repeat (2) @(negedge clk);
    rst2 = 1'b0; rst8 = 1'b0;

    // Identity times B.
    set_n2(1, 0, 0, 1, 5, 6, 7, 8);
    load(2);
    run_mm(2, 1'b0);
    check("ident_c11", 32'(mem2[11]), 32'd8);

    // General product.
    set_n2(1, 2, 3, 4, 5, 6, 7, 8);
    load(2);
    run_mm(2, 1'b0);
    check("gen_c00", 32'(mem2[8]), 32'd19);
    check("gen_c11", 32'(mem2[11]), 32'd50);

    // Accumulator wrap.
    set_n2(255, 255, 255, 255, 255, 255, 255, 255);
    load(2);
    run_mm(2, 1'b0);
    check("wrap_c01", 32'(mem2[9]), 32'd64514);

    // Extra start pulses while busy are ignored.
    set_n2(1, 2, 3, 4, 5, 6, 7, 8);
    load(2);
    run_mm(2, 1'b1);

    // Reset after the second write.
    load(2);
    base = wr_cnt2;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_cyc = 0;
    while (wr_cnt2 < base + 2 && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("midop_reached", 32'(wr_cnt2 - base), 32'd2);
    rst2 = 1'b1;
    #1;
    check("midrst_busy", 32'(busy2), 32'd0);
    check("midrst_we", 32'(we2), 32'd0);
    check("midrst_r_addr", 32'(r_addr2), 32'd0);
    check("midrst_w_addr", 32'(w_addr2), 32'd0);
    check("midrst_w_data", 32'(w_data2), 32'd0);
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_writes", 32'(wr_cnt2 - base), 32'd2);
    check("midrst_done_low", 32'(done2), 32'd0);
    check("midrst_c01_kept", 32'(mem2[9]), 32'(model_c(2, 0, 1)));
    check("midrst_c10_untouched", 32'(mem2[10]), 32'hBEEF);
    check("midrst_c11_untouched", 32'(mem2[11]), 32'hBEEF);
    run_mm(2, 1'b0);

    // Random N=2 operands.
    for (int t = 0; t < 3; t++) begin
      for (int e = 0; e < 4; e++) begin
        a_m[e] = $urandom_range(0, 255);
        b_m[e] = $urandom_range(0, 255);
      end
      load(2);
      run_mm(2, 1'b0);
    end

    // N=8: identity times a ramp, then random operands.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        a_m[r*8+c] = (r == c) ? 1 : 0;
        b_m[r*8+c] = r*8 + c;
      end
    end
    load(8);
    run_mm(8, 1'b0);
    check("n8_c_last", 32'(mem8[191]), 32'd63);
    for (int e = 0; e < 64; e++) begin
      a_m[e] = $urandom_range(0, 255);
      b_m[e] = $urandom_range(0, 255);
    end
    load(8);
    run_mm(8, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
